// File: rtl/bram_loader.sv
// Purpose : byte-stream program/data loader for the instruction and data BRAMs;
//           holds the core in stall until a run command, then hands over the data BRAM.
// Latency : BRAM write enable rises the cycle after the 4th byte of a word is accepted
//           (min 5 cycles per word). Backpressure: s_ready drops in WRITE, RUN and ERROR.
//
// Ports:
//   clk, rst                         clock (rising edge), asynchronous active-high reset
//   s_valid, s_data, s_ready         byte stream in, byte taken when s_valid & s_ready
//   i_w_addr/dat/enb/byte_enb        instruction BRAM write port
//   d_w_addr/dat/enb/byte_enb        data BRAM write port
//   load_done                        1 = datapath owns the data BRAM write port
//   pc_stall                         holds the PC until the run command
//   error                            sticky protocol error
//   words_loaded                     saturating count of words written since reset
//
// Stream format: cmd, cnt_lo, cnt_hi, then cnt little-endian words.
//   'I' -> instruction BRAM, 'D' -> data BRAM, 'G' -> run. Anything else is an error.

module bram_loader #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WORDS  = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    input  logic [7:0]            s_data,
    output logic                  s_ready,
    output logic [ADDR_WIDTH-1:0] i_w_addr,
    output logic [DATA_WIDTH-1:0] i_w_dat,
    output logic                  i_w_enb,
    output logic [3:0]            i_w_byte_enb,
    output logic [ADDR_WIDTH-1:0] d_w_addr,
    output logic [DATA_WIDTH-1:0] d_w_dat,
    output logic                  d_w_enb,
    output logic [3:0]            d_w_byte_enb,
    output logic                  load_done,
    output logic                  pc_stall,
    output logic                  error,
    output logic [15:0]           words_loaded
);

    localparam logic [7:0]  CMD_I   = 8'h49;
    localparam logic [7:0]  CMD_D   = 8'h44;
    localparam logic [7:0]  CMD_G   = 8'h47;
    localparam logic [15:0] MAX_CNT = 16'(MAX_WORDS);

    typedef enum logic [2:0] {
        IDLE,
        CNT_LO,
        CNT_HI,
        DATA,
        WRITE,
        RUN,
        ERROR
    } state_t;

    state_t                  state;
    logic                    target_d;   // 1 = current section goes to the data BRAM
    logic [7:0]              cnt_lo;
    logic [15:0]             count;
    logic [15:0]             index;
    logic [1:0]              byte_cnt;
    // Only the first three bytes are stored; the fourth goes straight to the port.
    logic [DATA_WIDTH-9:0]   word;
    logic [15:0]             new_count;
    logic [ADDR_WIDTH-1:0]   word_addr;
    logic                    accept;

    // Ready is decoded from the registered state; it is forced low while in reset.
    assign s_ready = !rst && ((state == IDLE) || (state == CNT_LO) ||
                              (state == CNT_HI) || (state == DATA));
    assign accept    = s_valid && s_ready;
    assign new_count = {s_data, cnt_lo};
    assign word_addr = ADDR_WIDTH'({index, 2'b00});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            target_d     <= 1'b0;
            cnt_lo       <= '0;
            count        <= '0;
            index        <= '0;
            byte_cnt     <= '0;
            word         <= '0;
            i_w_addr     <= '0;
            i_w_dat      <= '0;
            i_w_enb      <= 1'b0;
            i_w_byte_enb <= '0;
            d_w_addr     <= '0;
            d_w_dat      <= '0;
            d_w_enb      <= 1'b0;
            d_w_byte_enb <= '0;
            load_done    <= 1'b0;
            pc_stall     <= 1'b1;
            error        <= 1'b0;
            words_loaded <= '0;
        end else begin
            // Enables are single-cycle pulses; address and data hold between writes.
            i_w_enb      <= 1'b0;
            i_w_byte_enb <= '0;
            d_w_enb      <= 1'b0;
            d_w_byte_enb <= '0;

            case (state)
                IDLE: begin
                    if (accept) begin
                        case (s_data)
                            CMD_I: begin
                                target_d <= 1'b0;
                                state    <= CNT_LO;
                            end
                            CMD_D: begin
                                target_d <= 1'b1;
                                state    <= CNT_LO;
                            end
                            CMD_G: begin
                                state     <= RUN;
                                pc_stall  <= 1'b0;
                                load_done <= 1'b1;
                            end
                            default: begin
                                state <= ERROR;
                                error <= 1'b1;
                            end
                        endcase
                    end
                end

                CNT_LO: begin
                    if (accept) begin
                        cnt_lo <= s_data;
                        state  <= CNT_HI;
                    end
                end

                CNT_HI: begin
                    if (accept) begin
                        if (new_count == 16'd0) begin
                            state <= IDLE;
                        end else if (new_count > MAX_CNT) begin
                            state <= ERROR;
                            error <= 1'b1;
                        end else begin
                            count    <= new_count;
                            index    <= '0;
                            byte_cnt <= '0;
                            state    <= DATA;
                        end
                    end
                end

                DATA: begin
                    if (accept) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            // Fourth byte: launch the write directly from the input.
                            state <= WRITE;
                            if (target_d) begin
                                d_w_enb      <= 1'b1;
                                d_w_byte_enb <= 4'b1111;
                                d_w_addr     <= word_addr;
                                d_w_dat      <= {s_data, word};
                            end else begin
                                i_w_enb      <= 1'b1;
                                i_w_byte_enb <= 4'b1111;
                                i_w_addr     <= word_addr;
                                i_w_dat      <= {s_data, word};
                            end
                        end else begin
                            word[{byte_cnt, 3'b000} +: 8] <= s_data;
                        end
                    end
                end

                WRITE: begin
                    index <= index + 16'd1;
                    if (words_loaded != 16'hFFFF) begin
                        words_loaded <= words_loaded + 16'd1;
                    end
                    if (index + 16'd1 == count) begin
                        state <= IDLE;
                    end else begin
                        state <= DATA;
                    end
                end

                RUN: begin
                    state <= RUN;
                end

                ERROR: begin
                    state <= ERROR;
                end

                default: begin
                    state <= ERROR;
                    error <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bram_loader.sv
// Purpose : self-checking bench for bram_loader (table vectors, directed corner
//           sequences, random streams against a stream-parsing reference model).
// Latency/backpressure are observed through the write-port monitor and handshakes.

module tb_bram_loader;

    localparam int AW   = 12;
    localparam int DW   = 32;
    localparam int MAXW = 1024;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic [7:0]    s_data;
    logic          s_ready;
    logic [AW-1:0] i_w_addr;
    logic [DW-1:0] i_w_dat;
    logic          i_w_enb;
    logic [3:0]    i_w_byte_enb;
    logic [AW-1:0] d_w_addr;
    logic [DW-1:0] d_w_dat;
    logic          d_w_enb;
    logic [3:0]    d_w_byte_enb;
    logic          load_done;
    logic          pc_stall;
    logic          error;
    logic [15:0]   words_loaded;

    bram_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WORDS(MAXW)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .i_w_addr(i_w_addr), .i_w_dat(i_w_dat), .i_w_enb(i_w_enb), .i_w_byte_enb(i_w_byte_enb),
        .d_w_addr(d_w_addr), .d_w_dat(d_w_dat), .d_w_enb(d_w_enb), .d_w_byte_enb(d_w_byte_enb),
        .load_done(load_done), .pc_stall(pc_stall), .error(error), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          dport;
        logic [AW-1:0] addr;
        logic [DW-1:0] dat;
    } wr_t;

    typedef struct packed {
        logic [127:0]      bytes;   // right-aligned: first byte is the most significant used byte
        logic [4:0]        len;
        logic              thr;
        logic [1:0]        nw;
        logic [2:0]        wport;
        logic [2:0][11:0]  waddr;
        logic [2:0][31:0]  wdat;
        logic [15:0]       words;
        logic              stall;
        logic              done;
        logic              err;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    int   viol     = 0;
    int   cyc      = 0;
    int   last_wr  = -100;
    wr_t  got_q[$];
    wr_t  exp_q[$];
    logic [7:0] stim[$];
    int   m_words;
    logic m_stall, m_done, m_err;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Write-port monitor: captures every write and flags protocol violations.
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (rst) begin
            last_wr = -100;
        end else begin
            if (i_w_enb || d_w_enb) begin
                if (i_w_enb && d_w_enb) viol++;
                if (cyc - last_wr < 5) viol++;
                if (!pc_stall || error) viol++;
                last_wr = cyc;
                if (i_w_enb) begin
                    if (i_w_byte_enb != 4'hF || d_w_byte_enb != 4'h0) viol++;
                    got_q.push_back('{1'b0, i_w_addr, i_w_dat});
                end else begin
                    if (d_w_byte_enb != 4'hF || i_w_byte_enb != 4'h0) viol++;
                    got_q.push_back('{1'b1, d_w_addr, d_w_dat});
                end
            end else if (i_w_byte_enb != 4'h0 || d_w_byte_enb != 4'h0) begin
                viol++;
            end
        end
    end

    // Presents one byte until it is accepted; optional random idle cycles with junk data.
    task automatic send_byte(input logic [7:0] b, input logic thr);
        int   guard = 0;
        logic done  = 1'b0;
        logic rdy;
        while (!done) begin
            if (thr && $urandom_range(0, 2) == 0) begin
                s_valid = 1'b0;
                s_data  = 8'($urandom);
            end else begin
                s_valid = 1'b1;
                s_data  = b;
            end
            @(negedge clk);
            rdy = s_ready;
            @(posedge clk);
            #1;
            if (s_valid && rdy) done = 1'b1;
            guard++;
            if (!done && guard > 300) begin
                checks++;
                failures++;
                $display("FAIL handshake_timeout: byte %0h not accepted within 300 cycles", b);
                done = 1'b1;
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic do_reset();
        s_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        got_q.delete();
    endtask

    task automatic settle();
        repeat (8) @(posedge clk);
        #1;
    endtask

    // Reference model: parses the byte stream as sections and lists the writes it implies.
    task automatic model();
        int p = 0;
        int cnt;
        logic [7:0] cmd;
        exp_q.delete();
        m_words = 0;
        m_stall = 1'b1;
        m_done  = 1'b0;
        m_err   = 1'b0;
        while (p < stim.size()) begin
            cmd = stim[p];
            p++;
            if (cmd == 8'h47) begin
                m_stall = 1'b0;
                m_done  = 1'b1;
                break;
            end else if (cmd == 8'h49 || cmd == 8'h44) begin
                if (p + 2 > stim.size()) break;
                cnt = int'(stim[p]) + 256 * int'(stim[p+1]);
                p += 2;
                if (cnt > MAXW) begin
                    m_err = 1'b1;
                    break;
                end
                for (int w = 0; w < cnt; w++) begin
                    if (p + 4 > stim.size()) break;
                    exp_q.push_back('{cmd == 8'h44, AW'(w * 4),
                                      {stim[p+3], stim[p+2], stim[p+1], stim[p]}});
                    p += 4;
                    if (m_words < 65535) m_words++;
                end
            end else begin
                m_err = 1'b1;
                break;
            end
        end
    endtask

    task automatic compare_writes(input string tag);
        chk({tag, "_nwrites"}, got_q.size(), exp_q.size());
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            chk({tag, "_port"}, got_q[k].dport, exp_q[k].dport);
            chk({tag, "_addr"}, got_q[k].addr, exp_q[k].addr);
            chk({tag, "_dat"},  got_q[k].dat,  exp_q[k].dat);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) stim.push_back(w[8*k +: 8]);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        logic [7:0] b;
        int sh;

        rst = 1'b1;
        s_valid = 1'b0;
        s_data = 8'h00;

        // ---- reset state ----
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_pc_stall", pc_stall, 1);
        chk("rst_load_done", load_done, 0);
        chk("rst_error", error, 0);
        chk("rst_words", words_loaded, 0);
        chk("rst_enables", {i_w_enb, d_w_enb, i_w_byte_enb, d_w_byte_enb}, 0);
        chk("rst_addrs", {i_w_addr, d_w_addr}, 0);
        chk("rst_i_dat", i_w_dat, 0);
        chk("rst_d_dat", d_w_dat, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("post_rst_s_ready", s_ready, 1);
        @(posedge clk);
        #1;

        // ---- table-driven vectors ----
        tbl[0] = '{bytes: 128'({8'h49, 8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00}),
                   len: 5'd11, thr: 1'b0, nw: 2'd2, wport: 3'b000,
                   waddr: {12'h000, 12'h004, 12'h000}, wdat: {32'h0, 32'h00100093, 32'h00500013},
                   words: 16'd2, stall: 1'b1, done: 1'b0, err: 1'b0};
        tbl[1] = '{bytes: {8'h44, 8'h03, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                           8'h01, 8'h00, 8'h00, 8'h00, 8'h47},
                   len: 5'd16, thr: 1'b0, nw: 2'd3, wport: 3'b111,
                   waddr: {12'h008, 12'h004, 12'h000}, wdat: {32'h1, 32'h0, 32'h1},
                   words: 16'd3, stall: 1'b0, done: 1'b1, err: 1'b0};
        tbl[2] = '{bytes: 128'({8'h44, 8'h00, 8'h00, 8'h47}), len: 5'd4, thr: 1'b0, nw: 2'd0,
                   wport: 3'b000, waddr: '0, wdat: '0, words: 16'd0, stall: 1'b0, done: 1'b1, err: 1'b0};
        tbl[3] = '{bytes: 128'(8'h55), len: 5'd1, thr: 1'b0, nw: 2'd0,
                   wport: 3'b000, waddr: '0, wdat: '0, words: 16'd0, stall: 1'b1, done: 1'b0, err: 1'b1};
        tbl[4] = '{bytes: 128'({8'h49, 8'h01, 8'h04}), len: 5'd3, thr: 1'b0, nw: 2'd0,
                   wport: 3'b000, waddr: '0, wdat: '0, words: 16'd0, stall: 1'b1, done: 1'b0, err: 1'b1};
        tbl[5] = '{bytes: 128'({8'h49, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44}), len: 5'd7, thr: 1'b1,
                   nw: 2'd1, wport: 3'b000, waddr: '0, wdat: {32'h0, 32'h0, 32'h44332211},
                   words: 16'd1, stall: 1'b1, done: 1'b0, err: 1'b0};
        tbl[6] = '{bytes: 128'({8'h49, 8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD,
                                8'h49, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h47}),
                   len: 5'd15, thr: 1'b1, nw: 2'd2, wport: 3'b000,
                   waddr: '0, wdat: {32'h0, 32'h44332211, 32'hDDCCBBAA},
                   words: 16'd2, stall: 1'b0, done: 1'b1, err: 1'b0};
        tbl[7] = '{bytes: 128'({8'h44, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                                8'h44, 8'h01, 8'h00, 8'h21, 8'h43, 8'h65, 8'h87}),
                   len: 5'd14, thr: 1'b0, nw: 2'd2, wport: 3'b011,
                   waddr: '0, wdat: {32'h0, 32'h87654321, 32'h12345678},
                   words: 16'd2, stall: 1'b1, done: 1'b0, err: 1'b0};

        for (int t = 0; t < 8; t++) begin
            v = tbl[t];
            do_reset();
            for (int i = 0; i < int'(v.len); i++) begin
                sh = 8 * (int'(v.len) - 1 - i);
                b = v.bytes[sh +: 8];
                send_byte(b, v.thr);
                if (v.done && i == int'(v.len) - 1) begin
                    chk("g_next_pc_stall", pc_stall, 0);
                    chk("g_next_load_done", load_done, 1);
                    chk("g_next_s_ready", s_ready, 0);
                end
            end
            settle();
            chk("tbl_nwrites", got_q.size(), int'(v.nw));
            for (int k = 0; k < got_q.size() && k < int'(v.nw); k++) begin
                chk("tbl_port", got_q[k].dport, v.wport[k]);
                chk("tbl_addr", got_q[k].addr, v.waddr[k]);
                chk("tbl_dat", got_q[k].dat, v.wdat[k]);
            end
            chk("tbl_words", words_loaded, v.words);
            chk("tbl_pc_stall", pc_stall, v.stall);
            chk("tbl_load_done", load_done, v.done);
            chk("tbl_error", error, v.err);
            chk("tbl_s_ready", s_ready, !(v.done || v.err));
        end

        // ---- write latency and hold ----
        do_reset();
        send_byte(8'h49, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        chk("lat_i_w_enb", i_w_enb, 1);
        chk("lat_d_w_enb", d_w_enb, 0);
        chk("lat_i_w_addr", i_w_addr, 0);
        chk("lat_i_w_dat", i_w_dat, 32'h44332211);
        chk("lat_byte_enb", i_w_byte_enb, 4'hF);
        chk("lat_s_ready", s_ready, 0);
        @(posedge clk);
        #1;
        chk("hold_i_w_enb", i_w_enb, 0);
        chk("hold_i_w_dat", i_w_dat, 32'h44332211);
        chk("hold_s_ready", s_ready, 1);
        chk("hold_words", words_loaded, 1);

        // ---- reset mid-word, then a throttled reload ----
        do_reset();
        send_byte(8'h49, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        settle();
        chk("midword_no_write", got_q.size(), 0);
        #2 rst = 1'b1;
        #1;
        chk("midrst_s_ready", s_ready, 0);
        chk("midrst_i_w_dat", i_w_dat, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        stim.delete();
        stim = '{8'h49, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        model();
        foreach (stim[i]) send_byte(stim[i], 1'b1);
        settle();
        compare_writes("midrst");
        chk("midrst_words", words_loaded, m_words);

        // ---- error persistence and recovery ----
        do_reset();
        send_byte(8'h55, 1'b0);
        chk("err_now", error, 1);
        chk("err_s_ready", s_ready, 0);
        s_valid = 1'b1;
        s_data = 8'h49;
        repeat (20) @(posedge clk);
        #1;
        s_valid = 1'b0;
        chk("err_persist", error, 1);
        chk("err_persist_stall", pc_stall, 1);
        chk("err_persist_done", load_done, 0);
        chk("err_persist_ready", s_ready, 0);
        rst = 1'b1;
        #1 chk("err_cleared", error, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("err_rst_ready", s_ready, 1);
        @(posedge clk);
        #1;

        // ---- random streams against the model ----
        for (int r = 0; r < 20; r++) begin
            int nsec;
            int cnt;
            int term;
            logic thr;
            logic [7:0] bad;
            stim.delete();
            nsec = $urandom_range(1, 3);
            for (int s = 0; s < nsec; s++) begin
                stim.push_back(($urandom_range(0, 1) == 1) ? 8'h44 : 8'h49);
                cnt = $urandom_range(0, 4);
                stim.push_back(8'(cnt));
                stim.push_back(8'h00);
                for (int w = 0; w < cnt; w++) push_word($urandom);
            end
            term = $urandom_range(0, 3);
            if (term == 1) begin
                stim.push_back(8'h47);
            end else if (term == 2) begin
                do bad = 8'($urandom); while (bad == 8'h49 || bad == 8'h44 || bad == 8'h47);
                stim.push_back(bad);
            end else if (term == 3) begin
                cnt = $urandom_range(MAXW + 1, 4000);
                stim.push_back(8'h49);
                stim.push_back(8'(cnt));
                stim.push_back(8'(cnt >> 8));
            end
            thr = 1'($urandom_range(0, 1));
            model();
            do_reset();
            foreach (stim[i]) send_byte(stim[i], thr);
            settle();
            compare_writes("rand");
            chk("rand_words", words_loaded, m_words);
            chk("rand_pc_stall", pc_stall, m_stall);
            chk("rand_load_done", load_done, m_done);
            chk("rand_error", error, m_err);
            chk("rand_s_ready", s_ready, !(m_done || m_err));
        end

        // ---- full-depth section (count == MAX_WORDS is legal) ----
        stim.delete();
        stim.push_back(8'h44);
        stim.push_back(8'(MAXW));
        stim.push_back(8'(MAXW >> 8));
        for (int w = 0; w < MAXW; w++) push_word($urandom);
        stim.push_back(8'h47);
        model();
        do_reset();
        foreach (stim[i]) send_byte(stim[i], 1'b0);
        settle();
        compare_writes("full");
        chk("full_last_addr", d_w_addr, 12'hFFC);
        chk("full_words", words_loaded, MAXW);
        chk("full_load_done", load_done, 1);
        chk("full_error", error, 0);

        chk("write_protocol_violations", viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
